// File: rtl/scs8hd_tbuf_arb_if.sv
// scs8hd_tbuf_arb_if: bundle between the tri-state bus arbiter and its
// requesters.
//   req  - level request per requester (driven by the requesters)
//   gnt  - one-hot grant, registered
//   teb  - active-low tri-state driver enables, always ~gnt
//   keep - bus keeper enable, high when no driver is enabled
//   busy - arbiter is in a grant or turnaround phase
// master: requester side.  slave: arbiter side.
interface scs8hd_tbuf_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] teb;
    logic            keep;
    logic            busy;

    modport master (output req, input gnt, input teb, input keep, input busy);
    modport slave  (input req, output gnt, output teb, output keep, output busy);
endinterface

// File: rtl/scs8hd_tbuf_arb.sv
// scs8hd_tbuf_arb: round-robin arbiter for one tri-state bus shared by NREQ
// inverter drivers with active-low enables. Enforces break-before-make with
// TURN dead cycles between owners and turns the bus keeper on whenever no
// driver is enabled. Every output is a flop; REQ never reaches TEB
// combinationally.
// Ports:
//   CLK   - clock, rising edge
//   RESET - asynchronous, active-high reset
//   bus   - slave modport: req in; gnt, teb, keep, busy out
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner, all drivers off, keeper on
// GRANT   | one driver enabled; hold counter running
// TURN    | dead time after a release; all drivers off, keeper on
module scs8hd_tbuf_arb #(
    parameter int NREQ    = 4,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    scs8hd_tbuf_arb_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Preempt once the grant has lasted MAXHOLD cycles. A ">=" compare lets a
    // request that shows up after that point still preempt the owner.
    localparam logic [7:0] HOLD_LAST = (MAXHOLD == 0) ? 8'd0 : 8'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] teb_q;
    logic            keep_q;
    logic            busy_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   own_q;
    logic [7:0]      hcnt_q;
    logic [3:0]      tcnt_q;

    logic            arb_hit;
    logic [PW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_vec;
    logic            others;
    logic            rel;
    logic [PW-1:0]   ptr_d;

    // Rotating priority scan: walk downward so the candidate closest to
    // ptr_q overwrites the others.
    always_comb begin
        int          pos;
        logic [PW-1:0] pos_w;
        arb_hit = 1'b0;
        arb_idx = '0;
        pos     = 0;
        pos_w   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            pos   = (int'(ptr_q) + j) % NREQ;
            pos_w = PW'(pos);
            if (bus.req[pos_w]) begin
                arb_hit = 1'b1;
                arb_idx = pos_w;
            end
        end
        arb_vec          = '0;
        arb_vec[arb_idx] = 1'b1;
    end

    always_comb begin
        others = |(bus.req & ~gnt_q);
        rel    = !bus.req[own_q] ||
                 ((MAXHOLD != 0) && (hcnt_q >= HOLD_LAST) && others);
        ptr_d  = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            teb_q   <= '1;
            keep_q  <= 1'b1;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            own_q   <= '0;
            hcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_TURN: begin
                    if ((state_q == ST_TURN) && (tcnt_q != 4'd0)) begin
                        tcnt_q <= tcnt_q - 4'd1;
                    end else if (arb_hit) begin
                        state_q <= ST_GRANT;
                        own_q   <= arb_idx;
                        gnt_q   <= arb_vec;
                        teb_q   <= ~arb_vec;
                        keep_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        hcnt_q  <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (rel) begin
                        // Release and the new owner can never share an edge;
                        // the next grant always waits out the turnaround.
                        state_q <= ST_TURN;
                        gnt_q   <= '0;
                        teb_q   <= '1;
                        keep_q  <= 1'b1;
                        ptr_q   <= ptr_d;
                        tcnt_q  <= 4'(TURN - 1);
                    end else if (hcnt_q != 8'hFF) begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    teb_q   <= '1;
                    keep_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.teb  = teb_q;
    assign bus.keep = keep_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_scs8hd_tbuf_arb.sv
// Bench for scs8hd_tbuf_arb: four instances with different NREQ/TURN/MAXHOLD
// settings run side by side. A reference model steps on every clock edge and
// queues the expected outputs; a monitor on the falling edge pops and compares
// them, and also checks the bus-safety invariants and a starvation bound.
module tb_scs8hd_tbuf_arb;

    localparam int NI = 4;
    localparam int NR [NI] = '{4, 4, 4, 8};
    localparam int TU [NI] = '{1, 2, 1, 3};
    localparam int MH [NI] = '{8, 8, 0, 5};

    bit   clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] req_v  [NI];
    logic [7:0] d_gnt  [NI];
    logic [7:0] d_teb  [NI];
    logic       d_keep [NI];
    logic       d_busy [NI];

    scs8hd_tbuf_arb_if #(.NREQ(4)) if0 ();
    scs8hd_tbuf_arb_if #(.NREQ(4)) if1 ();
    scs8hd_tbuf_arb_if #(.NREQ(4)) if2 ();
    scs8hd_tbuf_arb_if #(.NREQ(8)) if3 ();

    scs8hd_tbuf_arb #(.NREQ(4), .TURN(1), .MAXHOLD(8)) u0 (.CLK(clk), .RESET(rst), .bus(if0));
    scs8hd_tbuf_arb #(.NREQ(4), .TURN(2), .MAXHOLD(8)) u1 (.CLK(clk), .RESET(rst), .bus(if1));
    scs8hd_tbuf_arb #(.NREQ(4), .TURN(1), .MAXHOLD(0)) u2 (.CLK(clk), .RESET(rst), .bus(if2));
    scs8hd_tbuf_arb #(.NREQ(8), .TURN(3), .MAXHOLD(5)) u3 (.CLK(clk), .RESET(rst), .bus(if3));

    assign if0.req = req_v[0][3:0];
    assign if1.req = req_v[1][3:0];
    assign if2.req = req_v[2][3:0];
    assign if3.req = req_v[3];

    assign d_gnt[0] = {4'h0, if0.gnt};  assign d_teb[0] = {4'h0, if0.teb};
    assign d_gnt[1] = {4'h0, if1.gnt};  assign d_teb[1] = {4'h0, if1.teb};
    assign d_gnt[2] = {4'h0, if2.gnt};  assign d_teb[2] = {4'h0, if2.teb};
    assign d_gnt[3] = if3.gnt;          assign d_teb[3] = if3.teb;
    assign d_keep[0] = if0.keep;  assign d_busy[0] = if0.busy;
    assign d_keep[1] = if1.keep;  assign d_busy[1] = if1.busy;
    assign d_keep[2] = if2.keep;  assign d_busy[2] = if2.busy;
    assign d_keep[3] = if3.keep;  assign d_busy[3] = if3.busy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] msk(input int k);
        return 8'((1 << NR[k]) - 1);
    endfunction

    // ---------------- reference model ----------------
    // owner: granted requester or -1; done: grant cycles completed;
    // turn_left: dead cycles still to run; ptr: first requester to consider.
    int owner [NI];
    int done [NI];
    int turn_left [NI];
    int ptr [NI];

    typedef struct packed {
        logic [NI-1:0][7:0] gnt;
        logic [NI-1:0]      keep;
        logic [NI-1:0]      busy;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            owner[k] = -1; done[k] = 0; turn_left[k] = 0; ptr[k] = 0;
        end
    endtask

    function automatic int pick(input int k, input logic [7:0] r);
        int c;
        for (int j = 0; j < NR[k]; j++) begin
            c = (ptr[k] + j) % NR[k];
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input logic [7:0] r);
        int   o;
        logic oth;
        o = owner[k];
        if (o >= 0) begin
            done[k]++;
            oth = (r & ~(8'd1 << o)) != 8'd0;
            if (!r[o] || (MH[k] != 0 && done[k] >= MH[k] && oth)) begin
                owner[k] = -1;
                ptr[k] = (o + 1) % NR[k];
                turn_left[k] = TU[k];
            end
        end else begin
            if (turn_left[k] > 0) turn_left[k]--;
            if (turn_left[k] == 0) begin
                owner[k] = pick(k, r);
                done[k] = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            e.gnt[k]  = (owner[k] >= 0) ? 8'(1 << owner[k]) : 8'd0;
            e.keep[k] = (owner[k] < 0);
            e.busy[k] = (owner[k] >= 0) || (turn_left[k] > 0);
        end
        return e;
    endfunction

    // An asynchronous reset also overrides the expectation already queued
    // for the upcoming falling-edge compare.
    always @(posedge rst) begin
        model_reset();
        if (sb_q.size() > 0) sb_q[$] = model_out();
    end

    always @(posedge clk) begin
        if (rst) model_reset();
        else for (int k = 0; k < NI; k++) model_step(k, req_v[k]);
        sb_q.push_back(model_out());
        mon_en = 1'b1;
    end

    // ---------------- monitor ----------------
    logic [7:0] prev_teb [NI];
    int         wcnt [NI][8];

    initial for (int k = 0; k < NI; k++) prev_teb[k] = 8'hFF;

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [7:0] m, fell, rose;
        int maxw;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 0, 32'd0, 32'd1);
                e = model_out();
            end else begin
                e = sb_q.pop_front();
            end
            for (int k = 0; k < NI; k++) begin
                m = msk(k);
                chk("gnt",  k, d_gnt[k], e.gnt[k]);
                chk("teb",  k, d_teb[k], ~e.gnt[k] & m);
                chk("keep", k, d_keep[k], e.keep[k]);
                chk("busy", k, d_busy[k], e.busy[k]);
                chk("inv_onehot", k, ($countones(~d_teb[k] & m) <= 1), 1);
                chk("inv_teb_gnt", k, d_teb[k], ~d_gnt[k] & m);
                chk("inv_keep", k, d_keep[k], ((d_teb[k] & m) == m));
                fell = prev_teb[k] & ~d_teb[k] & m;
                rose = ~prev_teb[k] & d_teb[k] & m;
                chk("inv_bbm", k, (fell != 0) && (rose != 0), 0);
                prev_teb[k] = d_teb[k] | ~m;
                maxw = 0;
                for (int i = 0; i < NR[k]; i++) begin
                    if (rst || d_gnt[k][i] || !req_v[k][i]) wcnt[k][i] = 0;
                    else wcnt[k][i]++;
                    if (wcnt[k][i] > maxw) maxw = wcnt[k][i];
                end
                if (MH[k] != 0)
                    chk("wait_bound", k, (maxw > (NR[k] - 1) * (MH[k] + TU[k]) + TU[k] + 2), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_gnt(input int k, input logic [7:0] want, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (d_gnt[k] == want) break;
        end
        chk("wait_gnt", k, d_gnt[k], want);
    endtask

    // Raise pat, drop it after hold edges, and measure the grant window.
    task automatic pulse_run(input int k, input logic [7:0] pat, input int hold,
                             output int first, output int gcyc, output int tcyc);
        first = -1; gcyc = 0; tcyc = 0;
        req_v[k] = pat;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (d_gnt[k] == pat) begin
                gcyc++;
                if (first < 0) first = c;
            end else if (d_busy[k] && d_keep[k]) begin
                tcyc++;
            end
            if (c == hold) req_v[k] = '0;
        end
    endtask

    initial begin : stim
        int first, gcyc, tcyc, cnt;
        logic [7:0] want;
        for (int k = 0; k < NI; k++) req_v[k] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Reset in the middle of a grant, then regrant after release.
        @(posedge clk); #1 req_v[0] = 8'b0010;
        wait_gnt(0, 8'b0010, 5);
        @(posedge clk); #3 rst = 1'b1; #1;
        chk("rst_gnt", 0, d_gnt[0], 0);
        chk("rst_teb", 0, d_teb[0], 8'h0F);
        chk("rst_keep", 0, d_keep[0], 1);
        chk("rst_busy", 0, d_busy[0], 0);
        req_v[0] = 8'b0001;
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_regrant", 0, d_gnt[0], 8'b0001);
        req_v[0] = '0;
        repeat (4) @(posedge clk); #1;

        // Single requester for five cycles, TURN=1.
        pulse_run(0, 8'b0100, 5, first, gcyc, tcyc);
        chk("single_first", 0, first, 1);
        chk("single_len", 0, gcyc, 5);
        chk("single_turn", 0, tcyc, 1);
        chk("single_idle", 0, d_busy[0], 0);

        // One-cycle request.
        pulse_run(0, 8'b0001, 1, first, gcyc, tcyc);
        chk("pulse_first", 0, first, 1);
        chk("pulse_len", 0, gcyc, 1);
        chk("pulse_turn", 0, tcyc, 1);
        chk("pulse_idle", 0, d_busy[0], 0);

        // Round robin: all four held, MAXHOLD=8, TURN=2.
        req_v[1] = 8'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                want = (c < 8) ? 8'(1 << (s % 4)) : 8'd0;
                chk("rr_seq", 1, d_gnt[1], want);
            end
        end
        req_v[1] = '0;
        repeat (4) @(posedge clk); #1;

        // Preemption disabled: owner 0 keeps the bus until it lets go.
        req_v[2] = 8'b0011;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (d_gnt[2] == 8'b0001) cnt++;
        end
        chk("nopre_hold", 2, cnt, 30);
        req_v[2] = 8'b0010;
        @(posedge clk); #1;
        chk("nopre_gap", 2, d_gnt[2], 0);
        @(posedge clk); #1;
        chk("nopre_next", 2, d_gnt[2], 8'b0010);
        req_v[2] = '0;
        repeat (4) @(posedge clk); #1;

        // Random traffic: waiting requesters hold REQ; owners drop at random.
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) begin
                #2 rst = 1'b1;
                @(posedge clk); #3 rst = 1'b0;
            end
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) begin
                for (int i = 0; i < NR[k]; i++) begin
                    if (req_v[k][i]) begin
                        if (owner[k] == i && $urandom_range(3) == 0) req_v[k][i] = 1'b0;
                    end else if ($urandom_range(5) == 0) begin
                        req_v[k][i] = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < NI; k++) req_v[k] = '0;
        repeat (12) @(posedge clk); #1;
        for (int k = 0; k < NI; k++) chk("final_idle", k, {d_busy[k], d_keep[k]}, 2'b01);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
